// File: rtl/pwm_multi.sv
// pwm_multi: CHANNELS PWM outputs sharing one WIDTH-bit period counter with double-buffered
// thresholds and reload. Define PWM_CENTER_EN to build the center-aligned (up/down) counter mode.
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      res_ni,
    input  logic                      enable_i,
    input  logic                      load_i,
    input  logic [CHANNELS*WIDTH-1:0] set_thres_i,
    input  logic [CHANNELS*WIDTH-1:0] clr_thres_i,
    input  logic [WIDTH-1:0]          reload_i,
    input  logic                      mode_i,
    output logic                      load_pending_o,
    output logic                      period_o,
    output logic [WIDTH-1:0]          cnt_o,
    output logic [CHANNELS-1:0]       pwm_o
);
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // A threshold above the active reload can never be reached, so it never matches.
    function automatic logic thr_hit(input logic [WIDTH-1:0] cnt,
                                     input logic [WIDTH-1:0] thr,
                                     input logic [WIDTH-1:0] reload);
        return (cnt == thr) && (thr <= reload);
    endfunction

    logic [CHANNELS*WIDTH-1:0] stg_set_q, stg_set_d;
    logic [CHANNELS*WIDTH-1:0] stg_clr_q, stg_clr_d;
    logic [CHANNELS*WIDTH-1:0] act_set_q, act_set_d;
    logic [CHANNELS*WIDTH-1:0] act_clr_q, act_clr_d;
    logic [WIDTH-1:0]          stg_reload_q, stg_reload_d;
    logic [WIDTH-1:0]          act_reload_q, act_reload_d;
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic                      pending_q, pending_d;
    logic                      period_q, period_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      boundary_s;
    logic                      commit_s;
    logic [WIDTH-1:0]          set_k_s;
    logic [WIDTH-1:0]          clr_k_s;
    logic                      edge_v_s;

`ifdef PWM_CENTER_EN
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

    logic stg_mode_q, stg_mode_d;
    logic act_mode_q, act_mode_d;
    dir_e dir_q, dir_d;
    logic center_v_s;
`else
    logic unused_mode_s;
    assign unused_mode_s = mode_i;
`endif

    // Period boundary detection and commit qualification
    always_comb begin
        boundary_s = 1'b0;
`ifdef PWM_CENTER_EN
        if (!enable_i) begin
            boundary_s = 1'b0;
        end else if (act_mode_q) begin
            boundary_s = ((cnt_q == CNT_ZERO) && (dir_q == DIR_DOWN)) || (act_reload_q == CNT_ZERO);
        end else begin
            boundary_s = (cnt_q == act_reload_q);
        end
`else
        if (enable_i) begin
            boundary_s = (cnt_q == act_reload_q);
        end else begin
            boundary_s = 1'b0;
        end
`endif
        commit_s = boundary_s && pending_q;
    end

    // Staging capture and pending flag
    always_comb begin
        stg_set_d    = stg_set_q;
        stg_clr_d    = stg_clr_q;
        stg_reload_d = stg_reload_q;
        pending_d    = pending_q;
`ifdef PWM_CENTER_EN
        stg_mode_d   = stg_mode_q;
`endif
        if (load_i) begin
            stg_set_d    = set_thres_i;
            stg_clr_d    = clr_thres_i;
            stg_reload_d = reload_i;
            pending_d    = 1'b1;
`ifdef PWM_CENTER_EN
            stg_mode_d   = mode_i;
`endif
        end else if (commit_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Active register update; commit always copies the pre-load staging contents
    always_comb begin
        act_set_d    = act_set_q;
        act_clr_d    = act_clr_q;
        act_reload_d = act_reload_q;
`ifdef PWM_CENTER_EN
        act_mode_d   = act_mode_q;
`endif
        if (commit_s) begin
            act_set_d    = stg_set_q;
            act_clr_d    = stg_clr_q;
            act_reload_d = stg_reload_q;
`ifdef PWM_CENTER_EN
            act_mode_d   = stg_mode_q;
`endif
        end else begin
            act_set_d    = act_set_q;
            act_clr_d    = act_clr_q;
            act_reload_d = act_reload_q;
        end
    end

    // Period counter next state
    always_comb begin
        cnt_d = cnt_q;
`ifdef PWM_CENTER_EN
        dir_d = dir_q;
        if (!enable_i) begin
            cnt_d = cnt_q;
            dir_d = dir_q;
        end else if (boundary_s) begin
            // A running center period restarts at 1 (0 was the boundary); a mode change starts at 0.
            dir_d = DIR_UP;
            if (act_mode_d && (act_mode_d == act_mode_q) && (act_reload_d != CNT_ZERO)) begin
                cnt_d = CNT_ONE;
            end else begin
                cnt_d = CNT_ZERO;
            end
        end else if (!act_mode_q) begin
            cnt_d = cnt_q + CNT_ONE;
            dir_d = DIR_UP;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q == act_reload_q) begin
                cnt_d = cnt_q - CNT_ONE;
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
                dir_d = DIR_UP;
            end
        end else begin
            cnt_d = cnt_q - CNT_ONE;
            dir_d = DIR_DOWN;
        end
`else
        if (!enable_i) begin
            cnt_d = cnt_q;
        end else if (boundary_s) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
`endif
    end

    // Per-channel compare and period pulse
    always_comb begin
        pwm_d      = pwm_q;
        period_d   = 1'b0;
        set_k_s    = CNT_ZERO;
        clr_k_s    = CNT_ZERO;
        edge_v_s   = 1'b0;
`ifdef PWM_CENTER_EN
        center_v_s = 1'b0;
`endif
        if (enable_i) begin
            period_d = boundary_s;
            for (int k = 0; k < CHANNELS; k++) begin
                set_k_s = act_set_q[k*WIDTH +: WIDTH];
                clr_k_s = act_clr_q[k*WIDTH +: WIDTH];
                if (thr_hit(cnt_q, clr_k_s, act_reload_q)) begin
                    edge_v_s = 1'b0;
                end else if (thr_hit(cnt_q, set_k_s, act_reload_q)) begin
                    edge_v_s = 1'b1;
                end else begin
                    edge_v_s = pwm_q[k];
                end
`ifdef PWM_CENTER_EN
                if (dir_q == DIR_UP) begin
                    center_v_s = thr_hit(cnt_q, set_k_s, act_reload_q) ? 1'b1 : pwm_q[k];
                end else begin
                    center_v_s = thr_hit(cnt_q, clr_k_s, act_reload_q) ? 1'b0 : pwm_q[k];
                end
                pwm_d[k] = act_mode_q ? center_v_s : edge_v_s;
`else
                pwm_d[k] = edge_v_s;
`endif
            end
        end else begin
            pwm_d    = pwm_q;
            period_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!res_ni) begin
            stg_set_q    <= {(CHANNELS*WIDTH){1'b0}};
            stg_clr_q    <= {(CHANNELS*WIDTH){1'b0}};
            act_set_q    <= {(CHANNELS*WIDTH){1'b0}};
            act_clr_q    <= {(CHANNELS*WIDTH){1'b0}};
            stg_reload_q <= CNT_ZERO;
            act_reload_q <= CNT_ZERO;
            cnt_q        <= CNT_ZERO;
            pending_q    <= 1'b0;
            period_q     <= 1'b0;
            pwm_q        <= {CHANNELS{1'b0}};
`ifdef PWM_CENTER_EN
            stg_mode_q   <= 1'b0;
            act_mode_q   <= 1'b0;
            dir_q        <= DIR_UP;
`endif
        end else begin
            stg_set_q    <= stg_set_d;
            stg_clr_q    <= stg_clr_d;
            act_set_q    <= act_set_d;
            act_clr_q    <= act_clr_d;
            stg_reload_q <= stg_reload_d;
            act_reload_q <= act_reload_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            period_q     <= period_d;
            pwm_q        <= pwm_d;
`ifdef PWM_CENTER_EN
            stg_mode_q   <= stg_mode_d;
            act_mode_q   <= act_mode_d;
            dir_q        <= dir_d;
`endif
        end
    end

    assign load_pending_o = pending_q;
    assign period_o       = period_q;
    assign cnt_o          = cnt_q;
    assign pwm_o          = pwm_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed bench for pwm_multi (WIDTH=8, CHANNELS=4); the center-mode
// section is built only when PWM_CENTER_EN is defined.
module tb_pwm_multi;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;

    logic                      clk = 1'b0;
    logic                      res_ni;
    logic                      enable_i;
    logic                      load_i;
    logic [CHANNELS*WIDTH-1:0] set_thres_i;
    logic [CHANNELS*WIDTH-1:0] clr_thres_i;
    logic [WIDTH-1:0]          reload_i;
    logic                      mode_i;
    logic                      load_pending_o;
    logic                      period_o;
    logic [WIDTH-1:0]          cnt_o;
    logic [CHANNELS-1:0]       pwm_o;

    int total = 0;
    int bad   = 0;

    pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk(clk), .res_ni(res_ni), .enable_i(enable_i), .load_i(load_i),
        .set_thres_i(set_thres_i), .clr_thres_i(clr_thres_i), .reload_i(reload_i),
        .mode_i(mode_i), .load_pending_o(load_pending_o), .period_o(period_o),
        .cnt_o(cnt_o), .pwm_o(pwm_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int k, input logic [7:0] s, input logic [7:0] c);
        set_thres_i[k*WIDTH +: WIDTH] = s;
        clr_thres_i[k*WIDTH +: WIDTH] = c;
    endtask

    task automatic wait_cnt(input logic [7:0] val, input int budget);
        int n = 0;
        while (cnt_o !== val && n < budget) begin
            step(1);
            n++;
        end
        check("wait_cnt", 32'(cnt_o), 32'(val));
    endtask

    task automatic wait_period(input int budget);
        int n = 0;
        while (period_o !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        check("wait_period", 32'(period_o), 32'd1);
    endtask

`ifdef PWM_CENTER_EN
    // One center period (reload=5, ch0 set=clr=2), starting the cycle period_o is high.
    logic [7:0] c_cnt [10] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    logic [3:0] c_pwm [10] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
`endif

    initial begin
        int c;
        res_ni      = 1'b0;
        enable_i    = 1'b1;
        load_i      = 1'b1;
        mode_i      = 1'b0;
        reload_i    = 8'd9;
        set_thres_i = 32'h0102_0304;
        clr_thres_i = 32'h0506_0708;
        step(3);
        check("rst_cnt", 32'(cnt_o), 32'd0);
        check("rst_pwm", 32'(pwm_o), 32'd0);
        check("rst_period", 32'(period_o), 32'd0);
        check("rst_pending", 32'(load_pending_o), 32'd0);

        // ch0 2/7, ch1 set==clr, ch2 beyond reload, ch3 at zero
        res_ni   = 1'b1;
        enable_i = 1'b0;
        reload_i = 8'd9;
        set_ch(0, 8'd2, 8'd7);
        set_ch(1, 8'd4, 8'd4);
        set_ch(2, 8'd200, 8'd201);
        set_ch(3, 8'd0, 8'd0);
        step(1);
        check("load_pending", 32'(load_pending_o), 32'd1);
        check("load_cnt", 32'(cnt_o), 32'd0);
        load_i   = 1'b0;
        enable_i = 1'b1;
        step(1);
        check("commit_pending", 32'(load_pending_o), 32'd0);

        for (int i = 0; i < 20; i++) begin
            c = i % 10;
            check("edge_cnt", 32'(cnt_o), 32'(c));
            check("edge_period", 32'(period_o), (c == 0) ? 32'd1 : 32'd0);
            check("edge_pwm", 32'(pwm_o), (c >= 3 && c <= 7) ? 32'd1 : 32'd0);
            step(1);
        end

        // Mid-period reload change to 4 at cnt=3
        step(3);
        check("mid_cnt", 32'(cnt_o), 32'd3);
        reload_i = 8'd4;
        load_i   = 1'b1;
        step(1);
        load_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("mid_pending", 32'(load_pending_o), 32'd1);
            check("mid_old_cnt", 32'(cnt_o), 32'(4 + i));
            step(1);
        end
        for (int j = 0; j < 10; j++) begin
            check("new_cnt", 32'(cnt_o), 32'(j % 5));
            check("new_period", 32'(period_o), (j % 5 == 0) ? 32'd1 : 32'd0);
            check("new_pending", 32'(load_pending_o), 32'd0);
            check("new_pwm", 32'(pwm_o), (j >= 3) ? 32'd1 : 32'd0);
            step(1);
        end

        // Back to reload 9, then freeze at cnt=5
        reload_i = 8'd9;
        load_i   = 1'b1;
        step(1);
        load_i = 1'b0;
        wait_cnt(8'd5, 30);
        check("frz_pwm_entry", 32'(pwm_o), 32'd1);
        enable_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            check("frz_cnt", 32'(cnt_o), 32'd5);
            check("frz_pwm", 32'(pwm_o), 32'd1);
            check("frz_period", 32'(period_o), 32'd0);
        end
        enable_i = 1'b1;
        step(1);
        check("resume_cnt", 32'(cnt_o), 32'd6);
        step(2);
        check("resume_cnt8", 32'(cnt_o), 32'd8);
        check("resume_pwm", 32'(pwm_o), 32'd0);

`ifdef PWM_CENTER_EN
        reload_i = 8'd5;
        mode_i   = 1'b1;
        set_ch(0, 8'd2, 8'd2);
        set_ch(1, 8'd200, 8'd201);
        set_ch(2, 8'd200, 8'd201);
        set_ch(3, 8'd200, 8'd201);
        load_i = 1'b1;
        step(1);
        load_i = 1'b0;
        wait_period(40);
        step(1);
        wait_period(40);
        for (int i = 0; i < 10; i++) begin
            check("ctr_cnt", 32'(cnt_o), 32'(c_cnt[i]));
            check("ctr_pwm", 32'(pwm_o), 32'(c_pwm[i]));
            check("ctr_period", 32'(period_o), (i == 0) ? 32'd1 : 32'd0);
            step(1);
        end
        check("ctr_next_period", 32'(period_o), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator sharing one period counter across `CHANNELS` outputs of `WIDTH`-bit resolution. Per-channel set/clear thresholds and the shared reload value are double-buffered. A staging load is committed to the active registers only at a period boundary, so period and duty updates are glitch-free. It sits between the register/control front-end and the pad outputs and replaces single-channel PWM instances.

## Interface
- `WIDTH`, 8, counter and threshold width in bits (≥2)
- `CHANNELS`, 4, number of PWM outputs (≥1)

- `clk`  in  1  clock
- `res_ni`  in  1  reset; synchronous, active-low
- `enable_i`  in  1  counter run enable; 0 freezes counter and outputs
- `load_i`  in  1  capture strobe for the threshold, reload and mode inputs
- `set_thres_i`  in  CHANNELS*WIDTH  set thresholds; channel k at bits [k*WIDTH +: WIDTH]
- `clr_thres_i`  in  CHANNELS*WIDTH  clear thresholds, same packing
- `reload_i`  in  WIDTH  terminal count
- `mode_i`  in  1  0 = edge-aligned, 1 = center-aligned (needs PWM_CENTER_EN)
- `load_pending_o`  out  1  staging holds data not yet committed
- `period_o`  out  1  one-cycle pulse per period boundary
- `cnt_o`  out  WIDTH  current counter value
- `pwm_o`  out  CHANNELS  PWM outputs

## Operation
- Reset (res_ni=0 at a clk edge, overrides everything):
  - staging and active registers = 0, cnt = 0, dir = up.
  - pwm_o = 0, period_o = 0, load_pending_o = 0.
  - With active reload = 0 and clr = 0, the outputs stay 0 until the first commit.
- Staging: load_i=1 captures all threshold inputs, reload_i and mode_i into staging and sets pending=1.
- Boundary (evaluated only when enable_i=1):
  - Edge mode: cnt == active reload.
  - Center mode: cnt == 0 with dir = down, or active reload == 0.
- Commit: at a boundary with pending=1, staging is copied to active and pending clears.
- Load at the boundary cycle: the commit uses the pre-load staging contents (only if pending was already 1). The new values land in staging and pending ends at 1.
- Edge counter: cnt → 0 if cnt == reload, else cnt+1. Arithmetic is modulo 2^WIDTH. reload = 2^WIDTH−1 gives a full-range period.
- Period lengths:
  - Edge mode: reload+1 cycles.
  - Center mode: 2*reload cycles.
  - reload = 0: cnt stays 0 and every enabled cycle is a boundary.
- Edge compare, per channel k, on active values:
  - cnt == clr_k → pwm_o[k] = 0 (clear has priority).
  - Else cnt == set_k → pwm_o[k] = 1.
  - Else hold.
- enable_i=0:
  - cnt, dir and pwm_o hold; period_o = 0; no commit.
  - Staging still accepts load_i.

## Timing
- pwm_o[k] and period_o are registered: each changes one cycle after the cnt value that causes it.
- period_o is high in the cycle in which the active registers first hold the committed values.
- Commit latency after load_i: 1 to one full period. It is 1 cycle if the load coincides with the cycle just before a boundary.
- load_pending_o rises the cycle after load_i. It falls the cycle after the committing boundary.
- Threshold, reload or mode changes never affect the period in progress.
- Thresholds greater than the active reload never match; that output holds its value.

## Configuration
- Macro: PWM_CENTER_EN.
- Defined: the center-aligned counter is built.
  - The mode bit is staged and committed like the other active registers.
  - Counter: up from 0 to reload, then dir = down and count down to 0, then dir = up.
  - cnt == reload belongs to the up phase. cnt == 0 belongs to the down phase.
  - Compare: up phase with cnt == set_k → 1; down phase with cnt == clr_k → 0.
  - A mode change commits at a boundary with cnt = 0 and dir forced to up.
- Undefined: mode_i and the mode register are ignored, with no logic generated. The counter is always edge-aligned and dir is constant up.

## Test plan
- Reset: hold res_ni=0 for 3 cycles with load_i=1 and enable_i=1 → cnt_o=0, pwm_o=0, period_o=0, load_pending_o=0.
- Edge duty (WIDTH=8, CHANNELS=4): reload=9, ch0 set=2/clr=7, load, enable → pwm_o[0] high 5 of every 10 cycles; period_o every 10 cycles; other channels remain 0.
- Clear priority: ch1 set=clr=4, reload=9 → pwm_o[1] stays 0 indefinitely.
- Mid-period update: active reload=9; load reload=4 at cnt=3 → load_pending_o=1 until the wrap at 9; the next periods are 5 cycles long.
- Freeze: enable_i=0 for 7 cycles at cnt=5 → cnt_o stays 5, pwm_o frozen, no period_o; it resumes at 6.
- Center mode (PWM_CENTER_EN): reload=5, ch0 set=clr=2, mode_i=1 → period 10 cycles; pwm_o[0] high 6 of 10 cycles, from cnt=3 (up) through cnt=2 (down).
